fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with IF/ID latch and one-word skid buffer.
//
// Ports
//   CLK, nRST          clock; synchronous active-low reset
//   ihit, imemload     instruction memory handshake and returned word
//   imemREN, imemaddr  read request and fetch address (the PC register)
//   ifid_en            hazard-unit enable for the IF/ID latch
//   ifid_flush         hazard-unit flush of the IF/ID latch (bubble insert)
//   pcpause            hazard-unit PC hold
//   redirect, redirect_addr  taken branch/jump and its target
//   halt               halt committed downstream; freezes fetch until reset
//   ifid_instr, ifid_npc, ifid_valid  IF/ID latch contents
//   ifid_op, ifid_rs, ifid_rt         decoded fields of ifid_instr
//   bubble_cnt         saturating count of fetch-miss bubbles
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ifid_en,
  input  logic        ifid_flush,
  input  logic        pcpause,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [5:0]  ifid_op,
  output logic [4:0]  ifid_rs,
  output logic [4:0]  ifid_rt,
  output logic [15:0] bubble_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_npc, buf_npc_n;
  logic [31:0] instr_n, npc_n;
  logic        valid_n;
  logic [15:0] cnt_n;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign imemREN  = (state == RUN);
  assign imemaddr = pc;
  assign ifid_op  = ifid_instr[31:26];
  assign ifid_rs  = ifid_instr[25:21];
  assign ifid_rt  = ifid_instr[20:16];
  assign pc_inc   = pc + 32'd4;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_npc_n   = buf_npc;
    instr_n     = ifid_instr;
    npc_n       = ifid_npc;
    valid_n     = ifid_valid;
    cnt_n       = bubble_cnt;
    case (state)
      RUN: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pc_n        = redirect_addr;
          buf_instr_n = '0;
          buf_npc_n   = '0;
        end else if (ihit && ifid_en && !pcpause) begin
          pc_n    = pc_inc;
          instr_n = imemload;
          npc_n   = pc_inc;
          valid_n = 1'b1;
        end else if (ihit && !ifid_en && !pcpause) begin
          // Latch is stalled but memory answered: park the word, keep fetching order.
          buf_instr_n = imemload;
          buf_npc_n   = pc_inc;
          pc_n        = pc_inc;
          state_n     = HOLD;
        end else if (ifid_en) begin
          // Miss or PC pause with an open latch: insert a counted bubble.
          instr_n = '0;
          npc_n   = '0;
          valid_n = 1'b0;
          cnt_n   = sat_inc16(bubble_cnt);
        end
      end
      HOLD: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pc_n        = redirect_addr;
          buf_instr_n = '0;
          buf_npc_n   = '0;
          state_n     = RUN;
        end else if (ifid_en) begin
          instr_n = buf_instr;
          npc_n   = buf_npc;
          valid_n = 1'b1;
          state_n = RUN;
        end
      end
      default: ;
    endcase
    // Flush wins over any latch load in every state, but is not a counted bubble.
    if (ifid_flush) begin
      instr_n = '0;
      npc_n   = '0;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      buf_instr  <= '0;
      buf_npc    <= '0;
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      buf_instr  <= buf_instr_n;
      buf_npc    <= buf_npc_n;
      ifid_instr <= instr_n;
      ifid_npc   <= npc_n;
      ifid_valid <= valid_n;
      bubble_cnt <= cnt_n;
    end
  end

endmodule
